// File: rtl/icache_param.sv
// Direct-mapped instruction cache; misses refill a whole line one 64-bit beat per accepted cycle.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module icache_param #(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_strobe,
    input  logic [31:0] read_addr,
    input  logic        invalidate,
    output logic [31:0] read_data,
    output logic        stall,
    output logic [31:0] emi_if_address,
    output logic        emi_if_req,
    input  logic [63:0] emi_if_rdata,
    input  logic        emi_if_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int unsigned BEAT_W  = $clog2(LINE_BEATS);
    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned OFF_W   = 3 + BEAT_W;
    localparam int unsigned TAG_W   = 32 - OFF_W - IDX_W;
    localparam int unsigned ENTRIES = NUM_LINES * LINE_BEATS;

    typedef enum logic [1:0] {StIdle, StLookup, StFill, StDone} state_e;

    state_e                r_state, w_state_next;
    logic [31:2]           r_addr;
    logic [BEAT_W-1:0]     r_beat, w_beat_next;
    logic [NUM_LINES-1:0]  r_valid, w_valid_next;
    logic                  r_inv_pend, w_inv_pend_next;
    logic                  w_capture;
    logic [TAG_W-1:0]      r_tag [NUM_LINES];
    logic [63:0]           r_data [ENTRIES];

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [BEAT_W-1:0]     w_word_beat;
    logic                  w_hit;
    logic [63:0]           w_rd_beat;
    logic [31:0]           w_rd_word;
    logic                  w_last;
    logic                  w_fill_we;
    logic                  w_tag_we;

    assign w_idx       = r_addr[OFF_W +: IDX_W];
    assign w_tag       = r_addr[31 -: TAG_W];
    assign w_word_beat = r_addr[3 +: BEAT_W];
    // An invalidate arriving in the lookup cycle wins over a tag match.
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !invalidate;
    assign w_rd_beat   = r_data[{w_idx, w_word_beat}];
    assign w_rd_word   = r_addr[2] ? w_rd_beat[63:32] : w_rd_beat[31:0];
    assign w_last      = (r_beat == BEAT_W'(LINE_BEATS - 1));
    assign w_fill_we   = (r_state == StFill) && emi_if_valid;
    assign w_tag_we    = w_fill_we && w_last;

    always_comb begin
        w_state_next    = r_state;
        w_beat_next     = r_beat;
        w_valid_next    = r_valid;
        w_inv_pend_next = r_inv_pend;
        w_capture       = 1'b0;
        stall           = 1'b1;
        read_data       = '0;
        emi_if_req      = 1'b0;
        emi_if_address  = '0;
        unique case (r_state)
            StIdle: begin
                stall = read_strobe & reset;
                if (invalidate) w_valid_next = '0;
                if (read_strobe) begin
                    w_capture    = 1'b1;
                    w_state_next = StLookup;
                end
            end
            StLookup: begin
                if (invalidate) w_valid_next = '0;
                if (w_hit) begin
                    stall     = 1'b0;
                    read_data = w_rd_word;
                    if (read_strobe) w_capture = 1'b1;
                    else             w_state_next = StIdle;
                end else begin
                    w_beat_next  = '0;
                    w_state_next = StFill;
                end
            end
            StFill: begin
                emi_if_req     = 1'b1;
                emi_if_address = {r_addr[31:OFF_W], r_beat, 3'b000};
                // Defer invalidation so the line being filled is still returned first.
                if (invalidate) w_inv_pend_next = 1'b1;
                if (emi_if_valid) begin
                    if (w_last) begin
                        w_valid_next[w_idx] = 1'b1;
                        w_beat_next         = '0;
                        w_state_next        = StDone;
                    end else begin
                        w_beat_next = r_beat + 1'b1;
                    end
                end
            end
            StDone: begin
                stall           = 1'b0;
                read_data       = w_rd_word;
                w_state_next    = StIdle;
                w_inv_pend_next = 1'b0;
                if (invalidate || r_inv_pend) w_valid_next = '0;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_beat     <= '0;
            r_valid    <= '0;
            r_inv_pend <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_beat     <= w_beat_next;
            r_valid    <= w_valid_next;
            r_inv_pend <= w_inv_pend_next;
            if (w_capture) r_addr <= read_addr[31:2];
        end
    end

    // Storage arrays carry no reset; validity is tracked by r_valid alone.
    always_ff @(posedge clk) begin
        if (w_fill_we) r_data[{w_idx, r_beat}] <= emi_if_rdata;
        if (w_tag_we)  r_tag[w_idx] <= w_tag;
    end

`ifdef ICACHE_STATS_EN
    logic        w_hit_evt, w_miss_evt;
    logic [31:0] r_hits, r_misses;

    assign w_hit_evt  = (r_state == StLookup) && w_hit;
    assign w_miss_evt = (r_state == StLookup) && !w_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (w_hit_evt && (r_hits != 32'hffff_ffff))    r_hits   <= r_hits + 32'd1;
            if (w_miss_evt && (r_misses != 32'hffff_ffff)) r_misses <= r_misses + 32'd1;
        end
    end

    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;
`endif

endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param: expected words and refill beat addresses are queued
// when a fetch is issued and popped as the cache produces them.
module tb_icache_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_strobe;
    logic [31:0] read_addr;
    logic        invalidate;
    logic [31:0] read_data;
    logic        stall;
    logic [31:0] emi_if_address;
    logic        emi_if_req;
    logic [63:0] emi_if_rdata;
    logic        emi_if_valid;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q_data[$];
    logic [31:0] q_beat[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] magic(input logic [31:0] a);
        return (a >> 2) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Memory model: beat at A holds word A in [31:0] and word A+4 in [63:32].
    assign emi_if_rdata = {magic(emi_if_address + 32'd4), magic(emi_if_address)};

    icache_param dut (
        .clk            (clk),
        .reset          (reset),
        .read_strobe    (read_strobe),
        .read_addr      (read_addr),
        .invalidate     (invalidate),
        .read_data      (read_data),
        .stall          (stall),
        .emi_if_address (emi_if_address),
        .emi_if_req     (emi_if_req),
        .emi_if_rdata   (emi_if_rdata),
        .emi_if_valid   (emi_if_valid)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one fetch at posedge+1 and follow it until stall drops.
    task automatic do_read(input logic [31:0] addr, input bit miss, input int exp_lat,
                           input int inv_cyc, input bit toggle);
        int          c;
        bit          done;
        logic [31:0] base;
        c    = 0;
        done = 1'b0;
        base = addr & ~32'h1f;
        read_addr   = addr;
        read_strobe = 1'b1;
        q_data.push_back(magic(addr));
        if (miss) for (int b = 0; b < 4; b++) q_beat.push_back(base + 32'(8 * b));
        while (!done && c < 64) begin
            invalidate   = (c == inv_cyc);
            emi_if_valid = toggle ? c[0] : 1'b1;
            @(negedge clk);
            if (emi_if_req) begin
                if (q_beat.size() == 0) begin
                    chk("spurious_req", 32'(emi_if_req), 32'd0);
                end else begin
                    chk("beat_addr", emi_if_address, q_beat[0]);
                    if (emi_if_valid) void'(q_beat.pop_front());
                end
            end
            if (!stall) begin
                done = 1'b1;
                chk("latency", 32'(c), 32'(exp_lat));
                chk("rdata", read_data, q_data.pop_front());
                chk("beats_left", 32'(q_beat.size()), 32'd0);
                read_strobe = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        invalidate = 1'b0;
        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
            read_strobe = 1'b0;
            q_data.delete();
            q_beat.delete();
        end
    endtask

    initial begin
        reset        = 1'b1;
        read_strobe  = 1'b0;
        read_addr    = '0;
        invalidate   = 1'b0;
        emi_if_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(emi_if_req), 32'd0);
        chk("rst_addr", emi_if_address, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, then hits in the same line.
        do_read(32'h30, 1'b1, 6, -1, 1'b0);
        do_read(32'h3c, 1'b0, 1, -1, 1'b0);
        do_read(32'h38, 1'b0, 1, -1, 1'b0);
`ifdef ICACHE_STATS_EN
        chk("stat_hits", stat_hits, 32'd2);
        chk("stat_misses", stat_misses, 32'd1);
`endif

        // Conflict on index 1.
        do_read(32'h830, 1'b1, 6, -1, 1'b0);
        do_read(32'h30, 1'b1, 6, -1, 1'b0);

        // Throttled refill: valid low on every other cycle.
        do_read(32'h184, 1'b1, 10, -1, 1'b1);

        // Invalidate during lookup of a cached line forces a miss.
        do_read(32'h3c, 1'b1, 6, 1, 1'b0);

        // Invalidate mid-fill: data still returned, then everything cleared.
        do_read(32'h200, 1'b1, 6, 3, 1'b0);
        do_read(32'h200, 1'b1, 6, -1, 1'b0);
        do_read(32'h30, 1'b1, 6, -1, 1'b0);

        // Reset mid-fill abandons the line.
        emi_if_valid = 1'b1;
        read_addr    = 32'h600;
        read_strobe  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("fill_active", 32'(emi_if_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(emi_if_req), 32'd0);
        chk("mid_rst_addr", emi_if_address, 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_rdata", read_data, 32'd0);
        read_strobe = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(emi_if_req), 32'd0);
        @(posedge clk);
        #1;
        do_read(32'h30, 1'b1, 6, -1, 1'b0);
        do_read(32'h600, 1'b1, 6, -1, 1'b0);

        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
